// File: rtl/mem_move_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : mem_move_ctrl
//  Purpose  : Moves a block of bytes from one memory region to another
//             through a single 8-bit holding register. It does one byte at a
//             time: read the source, latch the byte into the holding
//             register, then write the register output to the destination.
//             The block sits between instruction decode (start/operands) and
//             the shared data-memory port.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Parameters
//    RD_LAT     memory read latency in cycles (>=1); rdata is valid RD_LAT
//               cycles after the mem_rd cycle
//  Ports
//    CLK        in   1  system clock, rising edge
//    reset      in   1  asynchronous active-high reset
//    start      in   1  move request, sampled only while idle
//    src_addr   in   8  first source address (captured at start)
//    dst_addr   in   8  first destination address (captured at start)
//    length     in   8  number of bytes to move, 0..255 (captured at start)
//    busy       out  1  move in progress
//    done       out  1  one-cycle completion pulse
//    mem_addr   out  8  shared memory address
//    mem_rd     out  1  memory read strobe
//    mem_wr     out  1  memory write strobe
//    mem_rdata  in   8  memory read data (consumed by the holding register)
//    mem_wdata  out  8  memory write data, straight from hold_q
//    hold_we    out  1  holding-register write enable
//    hold_clr   out  1  holding-register synchronous clear
//    hold_q     in   8  holding-register output
// ============================================================================
module mem_move_ctrl #(
  parameter int RD_LAT = 1
) (
  input  logic       CLK,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] src_addr,
  input  logic [7:0] dst_addr,
  input  logic [7:0] length,
  output logic       busy,
  output logic       done,
  output logic [7:0] mem_addr,
  output logic       mem_rd,
  output logic       mem_wr,
  input  logic [7:0] mem_rdata,
  output logic [7:0] mem_wdata,
  output logic       hold_we,
  output logic       hold_clr,
  input  logic [7:0] hold_q
);

  // WAIT lasts RD_LAT-1 cycles, so the counter runs from 0 to RD_LAT-2.
  localparam int WAIT_W = (RD_LAT > 2) ? $clog2(RD_LAT - 1) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'((RD_LAT > 1) ? RD_LAT - 2 : 0);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RD    = 3'd1,
    S_WAIT  = 3'd2,
    S_LATCH = 3'd3,
    S_WR    = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  state_t            state;
  state_t            state_next;
  logic [7:0]        src;
  logic [7:0]        dst;
  logic [7:0]        count;
  logic [WAIT_W-1:0] wait_cnt;

  // The read data never enters this block: the external holding register
  // captures it directly when hold_we is high. The port is kept so the
  // controller presents the complete memory interface.
  logic unused_rdata;
  assign unused_rdata = ^mem_rdata;

  // Write data is a pure pass-through of the holding register.
  assign mem_wdata = hold_q;

  // --------------------------------------------------------------------------
  // State and datapath registers
  // --------------------------------------------------------------------------
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      state    <= S_IDLE;
      src      <= 8'd0;
      dst      <= 8'd0;
      count    <= 8'd0;
      wait_cnt <= '0;
    end else begin
      state <= state_next;
      case (state)
        S_IDLE: begin
          if (start) begin
            src   <= src_addr;
            dst   <= dst_addr;
            count <= length;
          end
        end
        S_RD: begin
          wait_cnt <= '0;
        end
        S_WAIT: begin
          wait_cnt <= wait_cnt + WAIT_W'(1);
        end
        S_WR: begin
          // Pointers wrap modulo 256 independently.
          src   <= src + 8'd1;
          dst   <= dst + 8'd1;
          count <= count - 8'd1;
        end
        default: begin
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Next-state and output decode
  // --------------------------------------------------------------------------
  always_comb begin
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    mem_addr   = 8'd0;
    mem_rd     = 1'b0;
    mem_wr     = 1'b0;
    hold_we    = 1'b0;
    hold_clr   = 1'b0;

    case (state)
      S_IDLE: begin
        if (start) begin
          // Clear the holding register so a zero-length move or a stale
          // byte never leaks onto the write bus.
          hold_clr   = 1'b1;
          state_next = (length == 8'd0) ? S_DONE : S_RD;
        end
      end
      S_RD: begin
        busy       = 1'b1;
        mem_rd     = 1'b1;
        mem_addr   = src;
        state_next = (RD_LAT == 1) ? S_LATCH : S_WAIT;
      end
      S_WAIT: begin
        busy     = 1'b1;
        mem_addr = src;
        if (wait_cnt == WAIT_LAST) begin
          state_next = S_LATCH;
        end
      end
      S_LATCH: begin
        // Exactly RD_LAT cycles after the read strobe: rdata is valid now
        // and the holding register takes it on this edge.
        busy       = 1'b1;
        hold_we    = 1'b1;
        mem_addr   = src;
        state_next = S_WR;
      end
      S_WR: begin
        busy       = 1'b1;
        mem_wr     = 1'b1;
        mem_addr   = dst;
        // count still holds the pre-decrement value here.
        state_next = (count == 8'd1) ? S_DONE : S_RD;
      end
      S_DONE: begin
        done       = 1'b1;
        state_next = S_IDLE;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_move_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mem_move_ctrl
//  Purpose  : Directed self-checking bench for mem_move_ctrl. Two instances
//             are used, one with RD_LAT=1 and one with RD_LAT=3. Each has its
//             own memory model and holding-register model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mem_move_ctrl;

  logic CLK = 1'b0;
  logic reset;
  always #5 CLK = ~CLK;

  int tests_run    = 0;
  int tests_failed = 0;

  // ---------------- instance A: RD_LAT = 1 ----------------
  logic       start1;
  logic [7:0] src1, dst1, len1;
  logic       busy1, done1, rd1, wr1, we1, clr1;
  logic [7:0] addr1, rdata1, wdata1, hold1;
  logic [7:0] mem1 [256];
  logic [7:0] pipe1;

  mem_move_ctrl #(.RD_LAT(1)) dut1 (
    .CLK(CLK), .reset(reset), .start(start1),
    .src_addr(src1), .dst_addr(dst1), .length(len1),
    .busy(busy1), .done(done1), .mem_addr(addr1),
    .mem_rd(rd1), .mem_wr(wr1), .mem_rdata(rdata1), .mem_wdata(wdata1),
    .hold_we(we1), .hold_clr(clr1), .hold_q(hold1)
  );

  // Read data appears one cycle after the strobe and only then; every other
  // cycle it is zero, so a mistimed latch captures a wrong value.
  always @(posedge CLK) begin
    if (wr1) mem1[addr1] <= wdata1;
    pipe1 <= rd1 ? mem1[addr1] : 8'h00;
    if (clr1)     hold1 <= 8'h00;
    else if (we1) hold1 <= rdata1;
  end
  assign rdata1 = pipe1;

  // ---------------- instance B: RD_LAT = 3 ----------------
  logic       start3;
  logic [7:0] src3, dst3, len3;
  logic       busy3, done3, rd3, wr3, we3, clr3;
  logic [7:0] addr3, rdata3, wdata3, hold3;
  logic [7:0] mem3 [256];
  logic [7:0] pipe3 [3];

  mem_move_ctrl #(.RD_LAT(3)) dut3 (
    .CLK(CLK), .reset(reset), .start(start3),
    .src_addr(src3), .dst_addr(dst3), .length(len3),
    .busy(busy3), .done(done3), .mem_addr(addr3),
    .mem_rd(rd3), .mem_wr(wr3), .mem_rdata(rdata3), .mem_wdata(wdata3),
    .hold_we(we3), .hold_clr(clr3), .hold_q(hold3)
  );

  always @(posedge CLK) begin
    if (wr3) mem3[addr3] <= wdata3;
    pipe3[0] <= rd3 ? mem3[addr3] : 8'h00;
    pipe3[1] <= pipe3[0];
    pipe3[2] <= pipe3[1];
    if (clr3)     hold3 <= 8'h00;
    else if (we3) hold3 <= rdata3;
  end
  assign rdata3 = pipe3[2];

  // ---------------- results of the last run_move ----------------
  int         r_done, r_busy, r_rd, r_wr, r_clr, r_we, r_we_bad, r_both;
  logic [7:0] rd_log [16];
  logic [7:0] wr_log [16];

  task automatic drive(input bit sel, input logic st, input logic [7:0] s, d, l);
    if (!sel) begin start1 = st; src1 = s; dst1 = d; len1 = l; end
    else      begin start3 = st; src3 = s; dst3 = d; len3 = l; end
  endtask

  // Cycle k=0 is the cycle in which start is high. Every cycle is sampled
  // 1 time unit after the falling edge. Stops at the done pulse or after
  // 400 cycles (r_done stays -1).
  task automatic run_move(input bit sel, input logic [7:0] s, d, l, input bit poke);
    int   last_rd;
    int   lat;
    logic b, dn, rd, wr, we, clr;
    logic [7:0] a;
    lat = sel ? 3 : 1;
    r_done = -1; r_busy = 0; r_rd = 0; r_wr = 0; r_clr = 0;
    r_we = 0; r_we_bad = 0; r_both = 0; last_rd = -100;
    for (int k = 0; k < 400; k++) begin
      @(negedge CLK);
      if (k == 0)               drive(sel, 1'b1, s, d, l);
      else if (poke && k == 4)  drive(sel, 1'b1, 8'h00, 8'h00, 8'h01);
      else                      drive(sel, 1'b0, 8'h5A, 8'hC3, 8'h07);
      #1;
      b  = sel ? busy3 : busy1;
      dn = sel ? done3 : done1;
      rd = sel ? rd3   : rd1;
      wr = sel ? wr3   : wr1;
      we = sel ? we3   : we1;
      clr = sel ? clr3 : clr1;
      a  = sel ? addr3 : addr1;
      if (b)   r_busy++;
      if (clr) r_clr++;
      if (rd) begin
        if (r_rd < 16) rd_log[r_rd] = a;
        r_rd++;
        last_rd = k;
      end
      if (wr) begin
        if (r_wr < 16) wr_log[r_wr] = a;
        r_wr++;
      end
      if (we) begin
        r_we++;
        if (k - last_rd != lat) r_we_bad++;
      end
      if (rd && wr) r_both++;
      if (dn) begin
        r_done = k;
        break;
      end
    end
    drive(sel, 1'b0, 8'h00, 8'h00, 8'h00);
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_reset();
    reset = 1'b1;
    drive(1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
    drive(1'b1, 1'b0, 8'h00, 8'h00, 8'h00);
    @(negedge CLK);
    @(negedge CLK);
    #1;
    tests_run++;
    if ({busy1, done1, rd1, wr1, we1, clr1} !== 6'b0) begin
      tests_failed++;
      $display("FAIL reset_flags1: got %b, want 000000", {busy1, done1, rd1, wr1, we1, clr1});
    end
    tests_run++;
    if (addr1 !== 8'h00) begin
      tests_failed++;
      $display("FAIL reset_addr1: got %h, want 00", addr1);
    end
    tests_run++;
    if ({busy3, done3, rd3, wr3, we3, clr3} !== 6'b0) begin
      tests_failed++;
      $display("FAIL reset_flags3: got %b, want 000000", {busy3, done3, rd3, wr3, we3, clr3});
    end
    @(negedge CLK);
    reset = 1'b0;
    @(negedge CLK);
    #1;
    tests_run++;
    if ({busy1, done1, addr1} !== 10'b0) begin
      tests_failed++;
      $display("FAIL idle_after_reset: got %h, want 000", {busy1, done1, addr1});
    end
  endtask

  task automatic test_basic();
    logic [7:0] exp [3];
    exp[0] = 8'hA1; exp[1] = 8'hB2; exp[2] = 8'hC3;
    mem1[8'h10] <= 8'hA1; mem1[8'h11] <= 8'hB2; mem1[8'h12] <= 8'hC3;
    mem1[8'h80] <= 8'h00; mem1[8'h81] <= 8'h00; mem1[8'h82] <= 8'h00;
    run_move(1'b0, 8'h10, 8'h80, 8'h03, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tests_run++;
      if (mem1[8'h80 + i] !== exp[i]) begin
        tests_failed++;
        $display("FAIL basic_mem[%0d]: got %h, want %h", i, mem1[8'h80 + i], exp[i]);
      end
      tests_run++;
      if (rd_log[i] !== 8'(8'h10 + i)) begin
        tests_failed++;
        $display("FAIL basic_rd_addr[%0d]: got %h, want %h", i, rd_log[i], 8'(8'h10 + i));
      end
    end
    tests_run++;
    if (r_done !== 10) begin
      tests_failed++;
      $display("FAIL basic_done_cycle: got %0d, want 10", r_done);
    end
    tests_run++;
    if (r_busy !== 9) begin
      tests_failed++;
      $display("FAIL basic_busy_cycles: got %0d, want 9", r_busy);
    end
    tests_run++;
    if ({r_rd, r_wr, r_clr} !== {32'd3, 32'd3, 32'd1}) begin
      tests_failed++;
      $display("FAIL basic_strobes: got rd=%0d wr=%0d clr=%0d, want 3 3 1", r_rd, r_wr, r_clr);
    end
    tests_run++;
    if ({r_we_bad, r_both} !== 64'd0) begin
      tests_failed++;
      $display("FAIL basic_timing: got we_bad=%0d both=%0d, want 0 0", r_we_bad, r_both);
    end
  endtask

  task automatic test_zero_len();
    run_move(1'b0, 8'h20, 8'h30, 8'h00, 1'b0);
    tests_run++;
    if (r_done !== 1) begin
      tests_failed++;
      $display("FAIL zero_done_cycle: got %0d, want 1", r_done);
    end
    tests_run++;
    if ({r_rd, r_wr, r_busy} !== 96'd0) begin
      tests_failed++;
      $display("FAIL zero_no_access: got rd=%0d wr=%0d busy=%0d, want 0 0 0", r_rd, r_wr, r_busy);
    end
    tests_run++;
    if (r_clr !== 1) begin
      tests_failed++;
      $display("FAIL zero_hold_clr: got %0d, want 1", r_clr);
    end
  endtask

  task automatic test_wrap();
    logic [7:0] exp_rd [3];
    logic [7:0] exp_wr [3];
    exp_rd[0] = 8'hFE; exp_rd[1] = 8'hFF; exp_rd[2] = 8'h00;
    exp_wr[0] = 8'hFF; exp_wr[1] = 8'h00; exp_wr[2] = 8'h01;
    mem1[8'hFE] <= 8'h11; mem1[8'hFF] <= 8'h22;
    mem1[8'h00] <= 8'h33; mem1[8'h01] <= 8'h44;
    run_move(1'b0, 8'hFE, 8'hFF, 8'h03, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tests_run++;
      if (rd_log[i] !== exp_rd[i]) begin
        tests_failed++;
        $display("FAIL wrap_rd_addr[%0d]: got %h, want %h", i, rd_log[i], exp_rd[i]);
      end
      tests_run++;
      if (wr_log[i] !== exp_wr[i]) begin
        tests_failed++;
        $display("FAIL wrap_wr_addr[%0d]: got %h, want %h", i, wr_log[i], exp_wr[i]);
      end
      // Overlapping ranges moved in ascending order propagate the first byte.
      tests_run++;
      if (mem1[exp_wr[i]] !== 8'h11) begin
        tests_failed++;
        $display("FAIL wrap_mem[%0d]: got %h, want 11", i, mem1[exp_wr[i]]);
      end
    end
  endtask

  task automatic test_rdlat3();
    mem3[8'h20] <= 8'h5A; mem3[8'h21] <= 8'hA5;
    mem3[8'h40] <= 8'h00; mem3[8'h41] <= 8'h00;
    run_move(1'b1, 8'h20, 8'h40, 8'h02, 1'b0);
    tests_run++;
    if (r_done !== 11) begin
      tests_failed++;
      $display("FAIL lat3_done_cycle: got %0d, want 11", r_done);
    end
    tests_run++;
    if ({r_we, r_we_bad, r_busy} !== {32'd2, 32'd0, 32'd10}) begin
      tests_failed++;
      $display("FAIL lat3_latch: got we=%0d bad=%0d busy=%0d, want 2 0 10", r_we, r_we_bad, r_busy);
    end
    tests_run++;
    if ({mem3[8'h40], mem3[8'h41]} !== 16'h5AA5) begin
      tests_failed++;
      $display("FAIL lat3_mem: got %h%h, want 5AA5", mem3[8'h40], mem3[8'h41]);
    end
  endtask

  task automatic test_reset_mid();
    mem3[8'h30] <= 8'h01; mem3[8'h31] <= 8'h02; mem3[8'h32] <= 8'h03;
    mem3[8'h50] <= 8'hEE; mem3[8'h51] <= 8'hEE;
    mem3[8'h60] <= 8'h00; mem3[8'h61] <= 8'h00; mem3[8'h62] <= 8'h00;
    @(negedge CLK);
    drive(1'b1, 1'b1, 8'h30, 8'h50, 8'h03);
    // Byte 2: RD at cycle 6, WAIT at cycles 7 and 8.
    for (int k = 1; k <= 7; k++) begin
      @(negedge CLK);
      drive(1'b1, 1'b0, 8'h00, 8'h00, 8'h00);
    end
    #1;
    tests_run++;
    if ({busy3, rd3, we3, addr3} !== {1'b1, 1'b0, 1'b0, 8'h31}) begin
      tests_failed++;
      $display("FAIL mid_wait_state: got busy=%b rd=%b we=%b addr=%h, want 1 0 0 31",
               busy3, rd3, we3, addr3);
    end
    #1;
    reset = 1'b1;
    #1;
    tests_run++;
    if ({busy3, done3, rd3, wr3, we3, clr3, addr3} !== 14'b0) begin
      tests_failed++;
      $display("FAIL mid_reset_outputs: got %h, want 0000",
               {busy3, done3, rd3, wr3, we3, clr3, addr3});
    end
    @(negedge CLK);
    reset = 1'b0;
    @(negedge CLK);
    tests_run++;
    if ({mem3[8'h50], mem3[8'h51]} !== 16'h01EE) begin
      tests_failed++;
      $display("FAIL mid_partial_mem: got %h%h, want 01EE", mem3[8'h50], mem3[8'h51]);
    end
    run_move(1'b1, 8'h30, 8'h60, 8'h03, 1'b0);
    tests_run++;
    if (r_done !== 16) begin
      tests_failed++;
      $display("FAIL after_reset_done_cycle: got %0d, want 16", r_done);
    end
    tests_run++;
    if ({mem3[8'h60], mem3[8'h61], mem3[8'h62]} !== 24'h010203) begin
      tests_failed++;
      $display("FAIL after_reset_mem: got %h%h%h, want 010203",
               mem3[8'h60], mem3[8'h61], mem3[8'h62]);
    end
  endtask

  task automatic test_start_ignored();
    mem1[8'h10] <= 8'hA1; mem1[8'h11] <= 8'hB2; mem1[8'h12] <= 8'hC3;
    mem1[8'h90] <= 8'h00; mem1[8'h91] <= 8'h00; mem1[8'h92] <= 8'h00;
    run_move(1'b0, 8'h10, 8'h90, 8'h03, 1'b1);
    tests_run++;
    if ({mem1[8'h90], mem1[8'h91], mem1[8'h92]} !== 24'hA1B2C3) begin
      tests_failed++;
      $display("FAIL busy_start_mem: got %h%h%h, want A1B2C3",
               mem1[8'h90], mem1[8'h91], mem1[8'h92]);
    end
    tests_run++;
    if ({r_done, r_rd, r_clr} !== {32'd10, 32'd3, 32'd1}) begin
      tests_failed++;
      $display("FAIL busy_start_seq: got done=%0d rd=%0d clr=%0d, want 10 3 1", r_done, r_rd, r_clr);
    end
  endtask

  task automatic test_back_to_back();
    mem1[8'h40] <= 8'h7E;
    mem1[8'h41] <= 8'h00;
    run_move(1'b0, 8'h40, 8'h41, 8'h01, 1'b0);
    tests_run++;
    if ({r_done, 24'(mem1[8'h41])} !== {32'd4, 24'h7E}) begin
      tests_failed++;
      $display("FAIL b2b_first: got done=%0d mem=%h, want 4 7E", r_done, mem1[8'h41]);
    end
    // The next move starts the cycle right after done (controller back in IDLE).
    run_move(1'b0, 8'h41, 8'h42, 8'h01, 1'b0);
    tests_run++;
    if ({r_done, 24'(mem1[8'h42])} !== {32'd4, 24'h7E}) begin
      tests_failed++;
      $display("FAIL b2b_second: got done=%0d mem=%h, want 4 7E", r_done, mem1[8'h42]);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_zero_len();
    test_wrap();
    test_rdlat3();
    test_reset_mid();
    test_start_ignored();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
